// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back L1 data cache.
// Field widths are derived from the line count and the block size.
package dcache_pkg;

  localparam int NUM_LINES = 16;
  localparam int ADDR_W    = 32;
  localparam int BLOCK_W   = 256;
  localparam int WORD_BITS = 32;
  localparam int WORDS     = BLOCK_W / WORD_BITS;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int WORD_W    = $clog2(WORDS);
  localparam int OFF_W     = WORD_W + 2;
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W;

  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [BLOCK_W-1:0]   line_t;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  function automatic logic [ADDR_W-1:0] line_addr(tag_t tag, idx_t idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

  function automatic logic [WORD_BITS-1:0] get_word(line_t line, word_t w);
    return line[{w, 5'd0} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bundles of the data cache.
// cpu: master = pipeline MEM stage, slave = cache. mem: master = cache, slave = memory.
interface dcache_cpu_if;
  logic [dcache_pkg::ADDR_W-1:0]    cpu_addr_i;
  logic [dcache_pkg::WORD_BITS-1:0] cpu_data_i;
  logic                             cpu_MemRead_i;
  logic                             cpu_MemWrite_i;
  logic [dcache_pkg::WORD_BITS-1:0] cpu_data_o;
  logic                             cpu_stall_o;

  modport master (output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
                  input  cpu_data_o, cpu_stall_o);
  modport slave  (input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
                  output cpu_data_o, cpu_stall_o);
endinterface

interface dcache_mem_if;
  logic                           mem_enable_o;
  logic                           mem_write_o;
  logic [dcache_pkg::ADDR_W-1:0]  mem_addr_o;
  logic [dcache_pkg::BLOCK_W-1:0] mem_data_o;
  logic [dcache_pkg::BLOCK_W-1:0] mem_data_i;
  logic                           mem_ack_i;

  modport master (output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
                  input  mem_data_i, mem_ack_i);
  modport slave  (input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
                  output mem_data_i, mem_ack_i);
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage: combinational read of one line, and either a
// full-line refill (clean) or a single-word store (marks the line dirty).
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  idx_t                 idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output tag_t                 tag_o,
  output line_t                line_o,
  input  logic                 line_we_i,
  input  tag_t                 line_tag_i,
  input  line_t                line_data_i,
  input  logic                 word_we_i,
  input  word_t                word_sel_i,
  input  logic [WORD_BITS-1:0] word_data_i
);

  tag_t                 tag_mem  [NUM_LINES];
  line_t                data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_mem[idx_i];
  assign line_o  = data_mem[idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end else if (word_we_i) begin
      dirty_d[idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Payload arrays carry no reset; contents are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_mem[idx_i]  <= line_tag_i;
      data_mem[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_mem[idx_i][{word_sel_i, 5'd0} +: WORD_BITS] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller. Misses stall the
// CPU, optionally write back the dirty victim, refill the line, then replay as a hit.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  state_t            state_q, state_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  line_t             mem_data_q, mem_data_d;

  tag_t  req_tag;
  idx_t  req_idx;
  word_t req_word;
  logic  req, is_store, hit;
  logic  rd_valid, rd_dirty;
  tag_t  rd_tag;
  line_t rd_line;
  logic  line_we, word_we;
  logic  unused_byte_offset;

  assign req_tag            = cpu.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx            = cpu.cpu_addr_i[OFF_W +: IDX_W];
  assign req_word           = cpu.cpu_addr_i[2 +: WORD_W];
  assign unused_byte_offset = ^cpu.cpu_addr_i[1:0];

  // A simultaneous read+write is resolved as a store.
  assign is_store = cpu.cpu_MemWrite_i;
  assign req      = cpu.cpu_MemRead_i | cpu.cpu_MemWrite_i;
  assign hit      = rd_valid & (rd_tag == req_tag);

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (req_idx),
    .valid_o     (rd_valid),
    .dirty_o     (rd_dirty),
    .tag_o       (rd_tag),
    .line_o      (rd_line),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag),
    .line_data_i (mem.mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (req_word),
    .word_data_i (cpu.cpu_data_i)
  );

  assign cpu.cpu_stall_o = (state_q != IDLE) | (req & ~hit);
  assign cpu.cpu_data_o  = (state_q == IDLE && req && !is_store && hit)
                         ? get_word(rd_line, req_word) : '0;

  assign mem.mem_enable_o = mem_enable_q;
  assign mem.mem_write_o  = mem_write_q;
  assign mem.mem_addr_o   = mem_addr_q;
  assign mem.mem_data_o   = mem_data_q;

  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    line_we      = 1'b0;
    word_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          word_we = is_store;
        end else if (req && rd_valid && rd_dirty) begin
          state_d      = WRITEBACK;
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b1;
          mem_addr_d   = line_addr(rd_tag, req_idx);
          mem_data_d   = rd_line;
        end else if (req) begin
          state_d      = ALLOCATE;
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = line_addr(req_tag, req_idx);
        end
      end
      WRITEBACK: begin
        // Drop enable for one cycle so the fetch is a distinct request.
        if (mem_enable_q && mem.mem_ack_i) begin
          state_d      = ALLOCATE;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          mem_addr_d   = line_addr(req_tag, req_idx);
        end
      end
      ALLOCATE: begin
        if (!mem_enable_q) begin
          mem_enable_d = 1'b1;
        end else if (mem.mem_ack_i) begin
          line_we      = 1'b1;
          mem_enable_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  a_no_read_and_write: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(cpu.cpu_MemRead_i && cpu.cpu_MemWrite_i));

endmodule
